// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice, one nibble per clock, valid/ready on both sides.
// Optional subtract mode (in_sub port) when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one nibble per edge through the slice, idx counts up
// DONE  | result held with out_valid high until out_ready
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [NIBBLES-1:0][3:0]  a_q;
  logic [NIBBLES-1:0][3:0]  b_q;
  logic [NIBBLES-1:0][3:0]  sum_q;
  logic [NIBBLES-1:0][3:0]  sum_next;
  logic                     carry;
  logic [IW-1:0]            idx;
  logic [3:0]               a_nib;
  logic [3:0]               b_nib;
  logic [4:0]               slice;
  logic                     msb_cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic                     sub_q;
`endif

  always_comb begin
    a_nib = a_q[idx];
    b_nib = b_q[idx];
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    if (sub_q) b_nib = ~b_nib;
`endif
    slice         = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry};
    sum_next      = sum_q;
    sum_next[idx] = slice[3:0];
    // carry into bit 3 of the slice recovered from the bit's own sum
    msb_cin       = a_nib[3] ^ b_nib[3] ^ slice[3];
  end

  assign out_sum = sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum_q     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            sub_q    <= in_sub;
            carry    <= in_sub ? 1'b1 : in_cin;
`else
            carry    <= in_cin;
`endif
          end
        end
        RUN: begin
          sum_q <= sum_next;
          carry <= slice[4];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            out_cout  <= slice[4];
            out_ovf   <= msb_cin ^ slice[4];
            out_zero  <= (sum_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (NIBBLES=4, 16-bit).
// Subtract vectors run only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int total = 0;
  int bad = 0;
  int lat;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .in_sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout),
    .out_ovf(out_ovf),
    .out_zero(out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // accept operands, then wait (bounded) for out_valid; returns edges after accept
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic s, output int n);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; sub = s; in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin; sub = ~s;
    chk("in_ready_run", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] s, input logic c,
                           input logic o, input logic z);
    chk({tag, "_sum"}, 32'(out_sum), 32'(s));
    chk({tag, "_cout"}, 32'(out_cout), 32'(c));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
    chk({tag, "_zero"}, 32'(out_zero), 32'(z));
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic s, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez);
    int n;
    start_op(a, b, cin, s, n);
    chk({tag, "_latency"}, 32'(n), 32'd4);
    check_res(tag, es, ec, eo, ez);
    release_op();
  endtask

  initial begin
    logic [15:0] held;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    run_op("basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("ovf_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("nib_bnd", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    // backpressure: result must hold, in_valid pulses must not be taken
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    held = 16'h3333;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 16'hFFFF; in_b = 16'hFFFF;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(out_sum), 32'(held));
    end
    in_valid = 1'b0;
    release_op();
    run_op("after_bp", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    // reset while RUN is at idx=2
    @(negedge clk);
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_res("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("mid_rst_no_valid", 32'(seen), 32'd0);
    end
    run_op("post_rst", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_zero",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_off",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
